// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter and bus-cycle sequencer for an asynchronous SRAM with
// active-low ce/oe/we and a shared tri-state data bus. Each access runs
// IDLE -> SETUP -> STROBE x WAIT_CYCLES -> HOLD -> IDLE, so every transaction
// is followed by one IDLE cycle (bus turnaround and ce deassert gap).
//
// Optional feature macro: SRAM_ARB_FIXED_PRI_EN
//   defined   : fixed priority, port 0 wins a simultaneous request
//   undefined : round-robin, the port not granted last wins (port 0 after reset)
//
// Ports
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_pN_req/wr/adr/wdata     requester N qualifiers, held until o_pN_gnt
//   o_pN_gnt                  one-cycle pulse, qualifiers captured on this edge
//   o_pN_done                 one-cycle pulse in HOLD, access complete
//   o_pN_rdata                read data, valid with done, held until next read
//   o_ce, o_oe, o_we          SRAM enables, active low
//   o_adr                     SRAM address (registered)
//   io_data                   SRAM data, driven only for writes
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | pins deasserted, arbitrate, gnt pulse to the winner
// SETUP  | ce low, address (and write data) settle before the strobe
// STROBE | oe or we low for WAIT_CYCLES clocks, counted down in r_cnt
// HOLD   | ce low, strobe released, done pulse, write data still held
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_p0_req,
    input  logic                  i_p0_wr,
    input  logic [ADDR_WIDTH-1:0] i_p0_adr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    input  logic                  i_p1_req,
    input  logic                  i_p1_wr,
    input  logic [ADDR_WIDTH-1:0] i_p1_adr,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    output logic                  o_p0_gnt,
    output logic                  o_p1_gnt,
    output logic                  o_p0_done,
    output logic                  o_p1_done,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,
    output logic                  o_ce,
    output logic                  o_oe,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_adr,
    inout  logic [DATA_WIDTH-1:0] io_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Strobe counter counts WAIT_CYCLES-1 down to 0; 4 bits cover 1..15.
    localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_port;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;
    logic                  r_drive;

    logic                  w_any_req;
    logic                  w_sel1;
    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_adr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_take;
    logic                  w_strobe_last;
    logic                  w_wr_nxt;

    assign w_any_req = i_p0_req | i_p1_req;

`ifdef SRAM_ARB_FIXED_PRI_EN
    assign w_sel1 = i_p1_req & ~i_p0_req;
`else
    // r_last holds the port granted most recently; reset to 1 so port 0
    // wins the first contention.
    logic r_last;

    assign w_sel1 = i_p1_req & (~i_p0_req | ~r_last);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_last <= 1'b1;
        end else if (w_take) begin
            r_last <= w_sel1;
        end
    end
`endif

    assign w_sel_wr    = w_sel1 ? i_p1_wr    : i_p0_wr;
    assign w_sel_adr   = w_sel1 ? i_p1_adr   : i_p0_adr;
    assign w_sel_wdata = w_sel1 ? i_p1_wdata : i_p0_wdata;

    assign w_take        = (r_state == ST_IDLE) && w_any_req;
    assign w_strobe_last = (r_state == ST_STROBE) && (r_cnt == 4'd0);

    // Direction of the next cycle: taken from the request at grant,
    // otherwise from the latched transaction.
    assign w_wr_nxt = w_take ? w_sel_wr : r_wr;

    always_comb begin
        w_state_nxt = r_state;
        o_p0_gnt    = 1'b0;
        o_p1_gnt    = 1'b0;
        o_p0_done   = 1'b0;
        o_p1_done   = 1'b0;
        o_ce        = 1'b1;
        o_oe        = 1'b1;
        o_we        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_SETUP;
                    o_p1_gnt    = w_sel1;
                    o_p0_gnt    = ~w_sel1;
                end
            end
            ST_SETUP: begin
                o_ce        = 1'b0;
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                o_ce = 1'b0;
                o_oe = r_wr;
                o_we = ~r_wr;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_ce        = 1'b0;
                o_p0_done   = ~r_port;
                o_p1_done   = r_port;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_port     <= 1'b0;
            r_wr       <= 1'b0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_drive    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Bus is driven from SETUP through HOLD of a write only, and the
            // enable is a flop so it cannot glitch.
            r_drive <= (w_state_nxt != ST_IDLE) && w_wr_nxt;

            if (w_take) begin
                r_port  <= w_sel1;
                r_wr    <= w_sel_wr;
                r_adr   <= w_sel_adr;
                r_wdata <= w_sel_wdata;
            end

            if (r_state == ST_SETUP) begin
                r_cnt <= LP_CNT_LOAD;
            end else if ((r_state == ST_STROBE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Read data is sampled on the edge that closes the strobe, which
            // is also the edge entering HOLD, so rdata is valid with done.
            if (w_strobe_last && !r_wr) begin
                if (r_port) begin
                    r_p1_rdata <= io_data;
                end else begin
                    r_p0_rdata <= io_data;
                end
            end
        end
    end

    assign o_adr      = r_adr;
    assign o_p0_rdata = r_p0_rdata;
    assign o_p1_rdata = r_p1_rdata;
    assign io_data    = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and bus-cycle sequencer for the team's asynchronous SRAM, which has active-low chip, output and write enables and a shared tri-state data bus. Two requesters on the system clock (port 0 and port 1) issue single-word reads and writes through a req/gnt/done handshake. The block arbitrates between them and drives the SRAM pins with an explicit setup, strobe and hold sequence. It owns the data bus direction, so the SRAM is never driven from both sides.

## Interface
- ADDR_WIDTH, 16, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- WAIT_CYCLES, 2, strobe (oe/we low) length in clocks, legal range 1..15

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- p0_req / p1_req  in  1  request; held with its qualifiers until gnt
- p0_wr / p1_wr  in  1  1 = write, 0 = read
- p0_adr / p1_adr  in  ADDR_WIDTH  word address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted and qualifiers captured
- p0_done / p1_done  out  1  one-cycle pulse: access complete
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data; valid with done and held until that port's next read done
- ce, oe, we  out  1  SRAM enables, active low
- adr  out  ADDR_WIDTH  SRAM address
- data  inout  DATA_WIDTH  SRAM data, driven only during writes, otherwise high-Z

## Operation
- The state machine has four states: IDLE, SETUP, STROBE, HOLD. Each transaction runs IDLE → SETUP → STROBE ×WAIT_CYCLES → HOLD → IDLE.
- IDLE
  - ce = oe = we = 1 and data is high-Z.
  - If any req is high, the block pulses that port's gnt in this cycle and, on the edge, latches the port id, wr, adr and wdata.
- SETUP (1 cycle)
  - ce = 0, oe = we = 1, adr is valid.
  - On a write, data is driven with the latched wdata.
- STROBE (WAIT_CYCLES cycles, down-counter)
  - Read: oe = 0.
  - Write: we = 0 and data is driven.
  - On a read, the edge that ends the last STROBE cycle captures data into an internal register.
- HOLD (1 cycle)
  - ce = 0, oe = we = 1, adr is unchanged.
  - Write: data is still driven.
  - Read: data is high-Z.
  - The owning port's done pulses. On a read, that port's rdata updates at the edge that enters HOLD, so it is valid while done is high.
- Each transaction is followed by a mandatory IDLE cycle. This gives bus turnaround between a read and a following write, and gives ce a deassert gap.
- Arbitration happens only in IDLE.
  - Round-robin: when both ports request, the port not granted last wins.
  - A single requester always wins.
- adr and the tri-state enable are registered outputs. oe and we are never low at the same time.
- wr is sampled only at gnt. Changes to the inputs after gnt have no effect.

## Timing
- Reset values: ce = oe = we = 1, adr = 0, data high-Z, gnt = done = 0, rdata = 0. After reset, port 0 has round-robin priority.
- Latency: with gnt in cycle 0, SETUP is cycle 1, STROBE is cycles 2..1+W, HOLD/done is cycle 2+W, and the next gnt is possible in cycle 3+W. At W = 2, one access every 5 cycles.
- A req that is still high after done starts a new transaction at the next IDLE. Requesters that want a single access drop req after gnt.
- Both ports requesting continuously alternate strictly 0, 1, 0, 1 under round-robin.
- Reset asserted mid-transaction: the next edge goes to IDLE with all pins deasserted and the bus released. No done is issued for the aborted access, and the write may be incomplete.
- WAIT_CYCLES = 1 gives a single-cycle strobe. A counter width of 4 bits is sufficient.

## Configuration
- SRAM_ARB_FIXED_PRI_EN
  - Defined: fixed priority. Port 0 always wins a simultaneous request, and the round-robin pointer is removed.
  - Undefined (default): round-robin as described above.

## Test plan
- After reset, with no requests: ce, oe and we stay at 1, data is high-Z and all gnt/done are 0 for 20 cycles.
- Port 0 writes 0xBEEF to 0x0010 with W = 2.
  - gnt in cycle 0.
  - we = 0 in cycles 2–3 only, with data = 0xBEEF and adr = 0x0010 in cycles 1–4.
  - done in cycle 4.
  - The SRAM model holds 0xBEEF at 0x0010.
- Port 1 then reads 0x0010: oe = 0 for 2 cycles, p1_done pulses, p1_rdata = 0xBEEF, and data is never driven by the block.
- Both ports hold req continuously on different addresses: grants go 0, 1, 0, 1. With SRAM_ARB_FIXED_PRI_EN defined, only port 0 is granted.
- A read of 0x0001 is immediately followed by a write of 0x1234 to 0x0002: there is at least one cycle with data high-Z between oe rising and the block driving data. No X appears on data.
- reset_n is pulled low during the STROBE of a write: the next cycle has ce = we = 1 and data high-Z, no done is issued, and the next request is granted normally after reset is released.
